// File: rtl/seq_detect_pkg.sv
// ----------------------------------------------------------------------------
// seq_detect_pkg
//
// Purpose : Shared types and elaboration-time helpers for the parametrised
//           serial-pattern detector. The KMP transition function is evaluated
//           only on constants, so it folds into a lookup table at elaboration.
//
// Contents:
//   MaxPatW     - largest supported pattern length
//   state_max_t - state vector wide enough for any legal PAT_W
//   state_w()   - state width for a given PAT_W, i.e. $clog2(PAT_W+1)
//   next_state()- KMP transition delta(k, b) for a given pattern
//
// Optional feature macro used by the top: SEQDET_STICKY_EN
// ----------------------------------------------------------------------------
package seq_detect_pkg;

    localparam int unsigned MaxPatW = 16;
    localparam int unsigned PatIdxW = 4;   // index width into a MaxPatW vector
    localparam int unsigned SeqIdxW = 5;   // index width into a MaxPatW+1 vector

    // State vector for the widest legal pattern (0..16 needs 5 bits).
    typedef logic [4:0] state_max_t;

    // Number of bits needed to hold a matched-prefix length 0..pat_w.
    function automatic int unsigned state_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // delta(k, b): longest j <= pat_w such that the first j pattern bits equal
    // the last j bits of (first k pattern bits followed by b).
    // pattern[pat_w-1] is the first bit received. Out-of-range k yields 0.
    function automatic state_max_t next_state(
        input logic [MaxPatW-1:0] pattern,
        input int unsigned        pat_w,
        input int unsigned        k,
        input logic               b
    );
        logic [MaxPatW:0] seq;   // seq[m] = m-th bit of the candidate string
        int unsigned      len;
        int unsigned      best;
        logic             ok;

        seq  = '0;
        best = 0;
        if (pat_w == 0 || pat_w > MaxPatW || k > pat_w) begin
            return '0;
        end

        for (int unsigned m = 0; m < MaxPatW; m++) begin
            if (m < k) begin
                seq[SeqIdxW'(m)] = pattern[PatIdxW'(pat_w - 1 - m)];
            end
        end
        seq[SeqIdxW'(k)] = b;
        len = k + 1;

        for (int unsigned j = 1; j <= MaxPatW; j++) begin
            if (j <= pat_w && j <= len) begin
                ok = 1'b1;
                for (int unsigned t = 0; t < MaxPatW; t++) begin
                    if (t < j) begin
                        if (seq[SeqIdxW'(len - j + t)] != pattern[PatIdxW'(pat_w - 1 - t)]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return state_max_t'(best);
    endfunction

endpackage

// File: rtl/seq_detect_fsm.sv
// ----------------------------------------------------------------------------
// seq_detect_fsm
//
// Purpose : Moore state machine of the serial-pattern detector. The state is
//           the length of the longest suffix of consumed bits that is also a
//           prefix of PATTERN. Transitions come from a constant KMP table.
//
// Ports   :
//   i_clk        - clock, all state changes on posedge
//   i_reset      - synchronous active-high reset
//   i_in         - serial data bit
//   i_valid      - consume i_in this cycle; state holds otherwise
//   i_overlap    - 1: overlapping matches, 0: restart from 0 after a match
//   o_state      - current matched-prefix length (registered)
//   o_match      - registered decode of state == PAT_W
//   o_match_next - strobe: the edge at the end of this cycle enters the
//                  full-match state
// ----------------------------------------------------------------------------
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int unsigned       PAT_W   = 3,
    parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(3'b101),
    localparam int unsigned      SW      = state_w(PAT_W)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_in,
    input  logic          i_valid,
    input  logic          i_overlap,
    output logic [SW-1:0] o_state,
    output logic          o_match,
    output logic          o_match_next
);

    localparam int unsigned   NumSt  = 2 ** SW;
    localparam logic [SW-1:0] StFull = SW'(PAT_W);

    // Transition tables indexed by the base state, one per input bit value.
    // Rows beyond PAT_W are unreachable and tied to 0.
    logic [SW-1:0] w_delta0 [NumSt];
    logic [SW-1:0] w_delta1 [NumSt];

    for (genvar k = 0; k < NumSt; k++) begin : g_delta
        assign w_delta0[k] = SW'(next_state(MaxPatW'(PATTERN), PAT_W, k, 1'b0));
        assign w_delta1[k] = SW'(next_state(MaxPatW'(PATTERN), PAT_W, k, 1'b1));
    end

    logic [SW-1:0] r_state;
    logic          r_match;
    logic [SW-1:0] w_base;
    logic [SW-1:0] w_next;

    // In non-overlap mode a completed match forgets all history, so the next
    // bit is evaluated as if it were the first after reset.
    always_comb begin
        w_base = r_state;
        if (r_state == StFull && !i_overlap) begin
            w_base = '0;
        end
        w_next = i_in ? w_delta1[w_base] : w_delta0[w_base];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= '0;
            r_match <= 1'b0;
        end else if (i_valid) begin
            r_state <= w_next;
            r_match <= (w_next == StFull);
        end
    end

    assign o_state      = r_state;
    assign o_match      = r_match;
    assign o_match_next = i_valid && (w_next == StFull);

endmodule

// File: rtl/seq_detect_param.sv
// ----------------------------------------------------------------------------
// seq_detect_param
//
// Purpose : Parametrised Moore serial-pattern detector with a valid
//           qualifier, runtime overlap mode and a saturating hit counter.
//           With default parameters and overlap=1 it behaves as the classic
//           four-state "101" detector.
//
// Parameters:
//   PAT_W   - pattern length, 1..16
//   PATTERN - pattern bits, PATTERN[PAT_W-1] received first
//   CNT_W   - hit counter width, 1..32
//
// Ports   :
//   clk       - clock
//   reset     - synchronous active-high reset, highest priority
//   in        - serial data bit
//   in_valid  - consume in this cycle; everything holds when 0
//   overlap   - 1: overlapping matches counted, 0: restart after a match
//   cnt_clr   - synchronous clear of hit_count (wins over an increment)
//   out       - registered match flag (state == PAT_W)
//   match_len - current matched-prefix length
//   hit_count - saturating number of matches
//   sticky    - (only with SEQDET_STICKY_EN) set on the first counted match,
//               cleared by cnt_clr or reset
//
// Optional feature macro: SEQDET_STICKY_EN
// ----------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned       PAT_W   = 3,
    parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(3'b101),
    parameter int unsigned       CNT_W   = 8,
    localparam int unsigned      SW      = state_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic [SW-1:0]    match_len,
    output logic [CNT_W-1:0] hit_count
`ifdef SEQDET_STICKY_EN
    ,
    output logic             sticky
`endif
);

    if (PAT_W < 1 || PAT_W > MaxPatW) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W out of range 1..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W out of range 1..32");
    end

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [SW-1:0] w_state;
    logic          w_match;
    logic          w_match_next;

    seq_detect_fsm #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_fsm (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_in         (in),
        .i_valid      (in_valid),
        .i_overlap    (overlap),
        .o_state      (w_state),
        .o_match      (w_match),
        .o_match_next (w_match_next)
    );

    logic [CNT_W-1:0] r_hit_count;

    // Counts on the same edge the FSM enters the full-match state, so the
    // count and out change together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count <= '0;
        end else if (cnt_clr) begin
            r_hit_count <= '0;
        end else if (w_match_next && r_hit_count != CntMax) begin
            r_hit_count <= r_hit_count + CNT_W'(1);
        end
    end

`ifdef SEQDET_STICKY_EN
    logic r_sticky;

    // Keeps setting on matches past saturation; only a clear drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= 1'b0;
        end else if (cnt_clr) begin
            r_sticky <= 1'b0;
        end else if (w_match_next) begin
            r_sticky <= 1'b1;
        end
    end

    assign sticky = r_sticky;
`endif

    assign out       = w_match;
    assign match_len = w_state;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four differently parametrised instances share
// one stimulus stream; each is compared every cycle against a model that
// keeps the raw bit history and searches it for the longest pattern prefix.
module tb_seq_detect_param;

    localparam int NDut = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r_reset = 1'b1;
    logic r_in = 1'b0;
    logic r_valid = 1'b0;
    logic r_overlap = 1'b1;
    logic r_clr = 1'b0;

    // 0: defaults (101, CNT_W 8); 1: 1101; 2: 101 with CNT_W 2; 3: PAT_W 1 pattern 0
    logic       a_out;  logic [1:0] a_len;  logic [7:0] a_cnt;
    logic       b_out;  logic [2:0] b_len;  logic [7:0] b_cnt;
    logic       c_out;  logic [1:0] c_len;  logic [1:0] c_cnt;
    logic       d_out;  logic [0:0] d_len;  logic [2:0] d_cnt;
`ifdef SEQDET_STICKY_EN
    logic a_sticky, b_sticky, c_sticky, d_sticky;
`endif

    seq_detect_param u_a (
        .clk(clk), .reset(r_reset), .in(r_in), .in_valid(r_valid), .overlap(r_overlap),
        .cnt_clr(r_clr), .out(a_out), .match_len(a_len), .hit_count(a_cnt)
`ifdef SEQDET_STICKY_EN
        , .sticky(a_sticky)
`endif
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) u_b (
        .clk(clk), .reset(r_reset), .in(r_in), .in_valid(r_valid), .overlap(r_overlap),
        .cnt_clr(r_clr), .out(b_out), .match_len(b_len), .hit_count(b_cnt)
`ifdef SEQDET_STICKY_EN
        , .sticky(b_sticky)
`endif
    );

    seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) u_c (
        .clk(clk), .reset(r_reset), .in(r_in), .in_valid(r_valid), .overlap(r_overlap),
        .cnt_clr(r_clr), .out(c_out), .match_len(c_len), .hit_count(c_cnt)
`ifdef SEQDET_STICKY_EN
        , .sticky(c_sticky)
`endif
    );

    seq_detect_param #(.PAT_W(1), .PATTERN(1'b0), .CNT_W(3)) u_d (
        .clk(clk), .reset(r_reset), .in(r_in), .in_valid(r_valid), .overlap(r_overlap),
        .cnt_clr(r_clr), .out(d_out), .match_len(d_len), .hit_count(d_cnt)
`ifdef SEQDET_STICKY_EN
        , .sticky(d_sticky)
`endif
    );

    logic        got_out [NDut];
    logic [31:0] got_len [NDut];
    logic [31:0] got_cnt [NDut];
    assign got_out[0] = a_out;  assign got_len[0] = 32'(a_len);  assign got_cnt[0] = 32'(a_cnt);
    assign got_out[1] = b_out;  assign got_len[1] = 32'(b_len);  assign got_cnt[1] = 32'(b_cnt);
    assign got_out[2] = c_out;  assign got_len[2] = 32'(c_len);  assign got_cnt[2] = 32'(c_cnt);
    assign got_out[3] = d_out;  assign got_len[3] = 32'(d_len);  assign got_cnt[3] = 32'(d_cnt);
`ifdef SEQDET_STICKY_EN
    logic got_sticky [NDut];
    assign got_sticky[0] = a_sticky;  assign got_sticky[1] = b_sticky;
    assign got_sticky[2] = c_sticky;  assign got_sticky[3] = d_sticky;
`endif

    int unsigned cfg_w   [NDut] = '{3, 4, 3, 1};
    logic [15:0] cfg_pat [NDut] = '{16'h5, 16'hD, 16'h5, 16'h0};
    int unsigned cfg_cw  [NDut] = '{8, 8, 2, 3};

    // Model: bit history since reset / since last non-overlapped match,
    // newest bit at position 0.
    logic [31:0] m_hist   [NDut];
    int unsigned m_len    [NDut];
    int unsigned m_cnt    [NDut];
    logic        m_sticky [NDut];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Longest j <= PAT_W whose last j history bits equal the first j pattern bits.
    function automatic int unsigned suffix_match(input int i);
        int unsigned best = 0;
        logic ok;
        for (int unsigned j = 1; j <= cfg_w[i]; j++) begin
            if (j <= m_len[i]) begin
                ok = 1'b1;
                for (int unsigned t = 0; t < j; t++) begin
                    if (m_hist[i][j - 1 - t] != cfg_pat[i][cfg_w[i] - 1 - t]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    task automatic model_edge();
        logic matched;
        for (int i = 0; i < NDut; i++) begin
            if (r_reset) begin
                m_hist[i] = '0; m_len[i] = 0; m_cnt[i] = 0; m_sticky[i] = 1'b0;
            end else begin
                matched = 1'b0;
                if (r_valid) begin
                    if (!r_overlap && suffix_match(i) == cfg_w[i]) begin
                        m_hist[i] = '0;
                        m_len[i]  = 0;
                    end
                    m_hist[i] = {m_hist[i][30:0], r_in};
                    if (m_len[i] < 32) m_len[i]++;
                    matched = (suffix_match(i) == cfg_w[i]);
                end
                if (r_clr) begin
                    m_cnt[i] = 0;
                    m_sticky[i] = 1'b0;
                end else if (matched) begin
                    m_sticky[i] = 1'b1;
                    if (m_cnt[i] < (32'd1 << cfg_cw[i]) - 1) m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic check_all();
        int unsigned s;
        for (int i = 0; i < NDut; i++) begin
            s = suffix_match(i);
            check_eq($sformatf("out%0d", i), 32'(got_out[i]), 32'(s == cfg_w[i]));
            check_eq($sformatf("len%0d", i), got_len[i], s);
            check_eq($sformatf("cnt%0d", i), got_cnt[i], m_cnt[i]);
`ifdef SEQDET_STICKY_EN
            check_eq($sformatf("sticky%0d", i), 32'(got_sticky[i]), 32'(m_sticky[i]));
`endif
        end
    endtask

    task automatic step(input logic b, input logic v, input logic ov, input logic clr,
                        input logic rst);
        r_in = b; r_valid = v; r_overlap = ov; r_clr = clr; r_reset = rst;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int exp_len [5];
        for (int i = 0; i < NDut; i++) begin
            m_hist[i] = '0; m_len[i] = 0; m_cnt[i] = 0; m_sticky[i] = 1'b0;
        end

        // Reset state
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("rst_out", 32'(a_out), 0);
        check_eq("rst_cnt", got_cnt[0], 0);

        // 10101 overlapping: len 1,2,3,2,3, two hits
        exp_len = '{1, 2, 3, 2, 3};
        for (int k = 0; k < 5; k++) begin
            step(((k % 2) == 0), 1'b1, 1'b1, 1'b0, 1'b0);
            check_eq("p1_len", got_len[0], exp_len[k]);
        end
        check_eq("p1_cnt", got_cnt[0], 2);
        check_eq("p1_out", 32'(a_out), 1);

        // Same stream non-overlapping: one hit, ends at len 1
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(((k % 2) == 0), 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("p2_cnt", got_cnt[0], 1);
        check_eq("p2_len", got_len[0], 1);

        // 1101 with a stall after bit 2: hit only after bit 5
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("p3_stall_len", got_len[1], 2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("p3_pre_out", 32'(b_out), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("p3_out", 32'(b_out), 1);
        check_eq("p3_cnt", got_cnt[1], 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("p3_hold_out", 32'(b_out), 1);

        // CNT_W=2 saturation on 101010101
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) step(((k % 2) == 0), 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("p4_sat", got_cnt[2], 3);
        check_eq("p4_cnt8", got_cnt[0], 4);

        // Clear on the match edge wins; next match counts 1
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("p5_clr_cnt", got_cnt[0], 0);
        check_eq("p5_clr_out", 32'(a_out), 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("p5_next_cnt", got_cnt[0], 1);

        // Reset mid-stream discards partial match
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("p6_len2", got_len[0], 2);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("p6_rst_len", got_len[0], 0);
        check_eq("p6_rst_out", 32'(a_out), 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("p6_len1", got_len[0], 1);
        check_eq("p6_out", 32'(a_out), 0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(1)),
                 ($urandom_range(99) < 75),
                 ($urandom_range(99) < 50),
                 ($urandom_range(99) < 5),
                 ($urandom_range(99) < 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
